// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port between N_REQ write-back
// sources. Each cycle at most one pending request is picked by round-robin
// and registered into a one-deep write-back stage. That stage drives the
// register file's ctrl_writeEnable / ctrl_writeReg / data_writeReg directly.
// Writes aimed at r0 are accepted and discarded: wb_we stays low and wb_drop
// pulses for one cycle instead.
//
// The register file accepts a write every cycle, so the grant never waits on
// the write-back stage. This gives one write per cycle with no bubbles.
//
// Optional build macro: REGFILE_WB_PRIO0_EN
//   Undefined: pure round-robin over all N_REQ requesters.
//   Defined:   requester 0 has fixed highest priority and leaves the pointer
//              alone. Requesters 1..N_REQ-1 rotate among themselves, and the
//              pointer never holds 0.

module regfile_wb_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 3
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [5*N_REQ-1:0]  req_reg,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                wb_we,
    output logic [4:0]          wb_reg,
    output logic [31:0]         wb_data,
    output logic [IDX_W-1:0]    wb_src,
    output logic                wb_drop
);

`ifdef REGFILE_WB_PRIO0_EN
    // Pointer ranges over 1..N_REQ-1 only; requester 0 bypasses it.
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] PTR_RST = '0;
`endif

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             wb_we_q;
    logic [4:0]       wb_reg_q;
    logic [31:0]      wb_data_q;
    logic [IDX_W-1:0] wb_src_q;
    logic             wb_drop_q;

    logic [N_REQ-1:0] grant;
    logic             grant_any;
    logic [IDX_W-1:0] gnt_idx;
    logic [4:0]       sel_reg;
    logic [31:0]      sel_data;

    // Pick the first valid requester from the pointer, and select its payload.
    always_comb begin
        int idx;
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        grant     = '0;
        grant_any = 1'b0;
        gnt_idx   = '0;
        sel_reg   = '0;
        sel_data  = '0;
        rr_ptr_d  = rr_ptr_q;
        idx       = 0;
`ifdef REGFILE_WB_PRIO0_EN
        if (req_valid[0]) begin
            grant_any = 1'b1;
            grant[0]  = 1'b1;
            sel_reg   = req_reg[4:0];
            sel_data  = req_data[31:0];
        end
        for (int k = 0; k < N_REQ - 1; k++) begin
            idx = 1 + ((int'(rr_ptr_q) - 1 + k) % (N_REQ - 1));
            if (!grant_any && req_valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = IDX_W'(idx);
                sel_reg    = req_reg[5*idx +: 5];
                sel_data   = req_data[32*idx +: 32];
                rr_ptr_d   = (idx == N_REQ - 1) ? IDX_W'(1) : IDX_W'(idx + 1);
            end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = IDX_W'(idx);
                sel_reg    = req_reg[5*idx +: 5];
                sel_data   = req_data[32*idx +: 32];
                rr_ptr_d   = IDX_W'((idx + 1) % N_REQ);
            end
        end
`endif
    end

    // The grant is masked while reset is held, so nothing reads as consumed.
    assign req_ready = ctrl_reset ? grant : '0;

    // Write-back stage: latch the granted request, or clear the strobes when idle.
    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            rr_ptr_q  <= PTR_RST;
            wb_we_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            wb_src_q  <= '0;
            wb_drop_q <= 1'b0;
        end else if (grant_any) begin
            rr_ptr_q  <= rr_ptr_d;
            wb_we_q   <= (sel_reg != 5'd0);
            wb_reg_q  <= sel_reg;
            wb_data_q <= sel_data;
            wb_src_q  <= gnt_idx;
            wb_drop_q <= (sel_reg == 5'd0);
        end else begin
            wb_we_q   <= 1'b0;
            wb_drop_q <= 1'b0;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_reg  = wb_reg_q;
    assign wb_data = wb_data_q;
    assign wb_src  = wb_src_q;
    assign wb_drop = wb_drop_q;

endmodule
